rate_enable_gen: RTL and testbench

- Upstream pacing stage for the 8-bit toggle counter and hex display path.
- Divides the board clock to a selectable tick rate and emits a one-cycle Pulse that drives the counter's Enable input.
- Also supports run/pause and a debounced-button single-step.
- Pulse is registered, so it can feed the counter's T chain directly.

---
 rtl/rate_enable_gen_pkg.sv | 31 +++
 rtl/rate_enable_gen_step_edge_sync.sv | 27 ++
 rtl/rate_enable_gen.sv | 70 +++++++
 tb/tb_rate_enable_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rate_enable_gen_pkg.sv
// Shared speed encodings and reload-value helper for the rate enable generator.
package rate_enable_gen_pkg;

  localparam int unsigned SPD_W    = 2;
  localparam int unsigned RELOAD_W = 64;

  typedef enum logic [SPD_W-1:0] {
    SPD_FAST = 2'b00,
    SPD_1HZ  = 2'b01,
    SPD_HALF = 2'b10,
    SPD_QTR  = 2'b11
  } speed_e;

  // Period minus one for a rate select; wide result so callers cast to CNT_W.
  function automatic logic [RELOAD_W-1:0] reload(input logic [SPD_W-1:0] s,
                                                 input int unsigned clk_hz);
    logic [RELOAD_W-1:0] hz;
    logic [RELOAD_W-1:0] r;
    hz = RELOAD_W'(clk_hz);
    r  = '0;
    case (speed_e'(s))
      SPD_FAST: r = '0;
      SPD_1HZ:  r = hz - RELOAD_W'(1);
      SPD_HALF: r = (hz << 1) - RELOAD_W'(1);
      SPD_QTR:  r = (hz << 2) - RELOAD_W'(1);
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rate_enable_gen_step_edge_sync.sv
// Two-flop synchronizer for the step button followed by a rising-edge detector.
module step_edge_sync (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic step_i,
  output logic edge_c_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= step_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_c_o = s2_q & ~s3_q;

endmodule

// File: rtl/rate_enable_gen.sv
// Divides the clock to a selectable tick rate and emits a registered one-cycle
// enable pulse, with run/pause and a synchronized single-step button.
module rate_enable_gen
  import rate_enable_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned CNT_W  = 28
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic [SPD_W-1:0] speed_i,
  input  logic             run_i,
  input  logic             step_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] count_o
);

  logic [SPD_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             periodic_c;
  logic             step_edge_c;
  logic [CNT_W-1:0] reload_new_c;
  logic [CNT_W-1:0] reload_cur_c;

  step_edge_sync u_step (
    .clk_i    (clock_i),
    .resetn_i (resetn_i),
    .step_i   (step_i),
    .edge_c_o (step_edge_c)
  );

  assign reload_new_c = CNT_W'(reload(speed_i, CLK_HZ));
  assign reload_cur_c = CNT_W'(reload(speed_q, CLK_HZ));

  // Priority: rate change restarts a full period, pause holds at reload, else count down.
  always_comb begin
    speed_d    = speed_q;
    cnt_d      = cnt_q;
    periodic_c = 1'b0;
    if (speed_i != speed_q) begin
      speed_d = speed_i;
      cnt_d   = reload_new_c;
    end else if (!run_i) begin
      cnt_d = reload_cur_c;
    end else if (cnt_q == '0) begin
      cnt_d      = reload_cur_c;
      periodic_c = 1'b1;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    pulse_d = periodic_c | step_edge_c;
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      speed_q <= speed_i;
      cnt_q   <= reload_new_c;
      pulse_q <= 1'b0;
    end else begin
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign count_o = cnt_q;

endmodule

// File: tb/tb_rate_enable_gen.sv
// Directed-vector bench for rate_enable_gen with CLK_HZ=4 (periods 1/4/8/16).
module tb_rate_enable_gen;
  import rate_enable_gen_pkg::*;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned CNT_W  = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic [1:0]       speed;
  logic             run;
  logic             step;
  logic             pulse;
  logic [CNT_W-1:0] count;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic             rstn;
    logic [1:0]       spd;
    logic             run;
    logic             stp;
    logic             exp_p;
    logic [CNT_W-1:0] exp_c;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  always #5 clk = ~clk;

  rate_enable_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clock_i  (clk),
    .resetn_i (resetn),
    .speed_i  (speed),
    .run_i    (run),
    .step_i   (step),
    .pulse_o  (pulse),
    .count_o  (count)
  );

  function automatic vec_t mk(input logic r, input logic [1:0] s, input logic rn,
                              input logic st, input logic p, input int c);
    vec_t v;
    v.rstn  = r;
    v.spd   = s;
    v.run   = rn;
    v.stp   = st;
    v.exp_p = p;
    v.exp_c = CNT_W'(c);
    return v;
  endfunction

  // Drive one vector, clock one edge, compare both outputs shortly after the edge.
  task automatic apply(input vec_t v, input string name);
    resetn = v.rstn;
    speed  = v.spd;
    run    = v.run;
    step   = v.stp;
    @(posedge clk);
    #1;
    n_run++;
    if (pulse !== v.exp_p) begin
      n_fail++;
      $display("FAIL %s pulse: got %b expected %b (t=%0t)", name, pulse, v.exp_p, $time);
    end
    n_run++;
    if (count !== v.exp_c) begin
      n_fail++;
      $display("FAIL %s count: got %0d expected %0d (t=%0t)", name, count, v.exp_c, $time);
    end
  endtask

  initial begin
    resetn = 1'b0;
    speed  = 2'b01;
    run    = 1'b1;
    step   = 1'b0;

    // Reset with 1 Hz, then release and watch two periods.
    tbl_a.push_back(mk(0, 1, 1, 0, 0, 3));
    tbl_a.push_back(mk(0, 1, 1, 0, 0, 3));
    tbl_a.push_back(mk(1, 1, 1, 0, 0, 2));
    tbl_a.push_back(mk(1, 1, 1, 0, 0, 1));
    tbl_a.push_back(mk(1, 1, 1, 0, 0, 0));
    tbl_a.push_back(mk(1, 1, 1, 0, 1, 3));
    tbl_a.push_back(mk(1, 1, 1, 0, 0, 2));
    tbl_a.push_back(mk(1, 1, 1, 0, 0, 1));
    tbl_a.push_back(mk(1, 1, 1, 0, 0, 0));
    tbl_a.push_back(mk(1, 1, 1, 0, 1, 3));
    // Fast rate: change edge yields no pulse, then continuous pulses.
    tbl_a.push_back(mk(1, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(1, 0, 1, 0, 1, 0));
    tbl_a.push_back(mk(1, 0, 1, 0, 1, 0));
    tbl_a.push_back(mk(1, 0, 1, 0, 1, 0));
    // Back to 1 Hz and step down to Count=2.
    tbl_a.push_back(mk(1, 1, 1, 0, 0, 3));
    tbl_a.push_back(mk(1, 1, 1, 0, 0, 2));

    // Run rises from a paused reload; step edge coincides with cnt==0.
    tbl_b.push_back(mk(1, 1, 1, 0, 0, 2));
    tbl_b.push_back(mk(1, 1, 1, 1, 0, 1));
    tbl_b.push_back(mk(1, 1, 1, 0, 0, 0));
    tbl_b.push_back(mk(1, 1, 1, 0, 1, 3));
    tbl_b.push_back(mk(1, 1, 1, 0, 0, 2));
    tbl_b.push_back(mk(1, 1, 1, 0, 0, 1));
    tbl_b.push_back(mk(1, 1, 1, 0, 0, 0));
    tbl_b.push_back(mk(1, 1, 1, 0, 1, 3));
    // Half rate, reset mid-count at 5 with a step edge in flight.
    tbl_b.push_back(mk(1, 2, 1, 0, 0, 7));
    tbl_b.push_back(mk(1, 2, 1, 1, 0, 6));
    tbl_b.push_back(mk(1, 2, 1, 0, 0, 5));
    tbl_b.push_back(mk(0, 2, 1, 0, 0, 7));
    for (int k = 6; k >= 0; k--) tbl_b.push_back(mk(1, 2, 1, 0, 0, k));
    tbl_b.push_back(mk(1, 2, 1, 0, 1, 7));
    tbl_b.push_back(mk(1, 2, 1, 0, 0, 6));

    foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("tblA[%0d]", i));

    // 1 Hz -> quarter rate at Count=2: full 16-cycle period, then every 16.
    apply(mk(1, 3, 1, 0, 0, 15), "spd_chg");
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 14; k >= 0; k--) apply(mk(1, 3, 1, 0, 0, k), $sformatf("qtr[%0d].%0d", rep, k));
      apply(mk(1, 3, 1, 0, 1, 15), $sformatf("qtr_tick[%0d]", rep));
    end

    // Paused: single step press, then held step, each give exactly one pulse.
    apply(mk(1, 1, 0, 0, 0, 3), "pause_chg");
    apply(mk(1, 1, 0, 0, 0, 3), "pause_hold");
    apply(mk(1, 1, 0, 1, 0, 3), "step1_e0");
    apply(mk(1, 1, 0, 0, 0, 3), "step1_e1");
    apply(mk(1, 1, 0, 0, 1, 3), "step1_e2");
    apply(mk(1, 1, 0, 0, 0, 3), "step1_e3");
    apply(mk(1, 1, 0, 0, 0, 3), "step1_e4");
    for (int i = 0; i < 10; i++) apply(mk(1, 1, 0, 1, (i == 2), 3), $sformatf("step_hold[%0d]", i));
    for (int i = 0; i < 3; i++) apply(mk(1, 1, 0, 0, 0, 3), $sformatf("step_rel[%0d]", i));

    foreach (tbl_b[i]) apply(tbl_b[i], $sformatf("tblB[%0d]", i));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
